// File: rtl/mini_src_pkg.sv
// Mini-SRC shared definitions: instruction opcodes (IR[31:27]), ALU function codes,
// the opcode-to-ALU-function mapping and the control sequencer state encoding.
package mini_src_pkg;

  // Instruction opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU function codes
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_OR   = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00011;
  localparam logic [4:0] ALU_ADD  = 5'b00100;
  localparam logic [4:0] ALU_SHR  = 5'b00101;
  localparam logic [4:0] ALU_SHRA = 5'b00110;
  localparam logic [4:0] ALU_SHL  = 5'b00111;
  localparam logic [4:0] ALU_ROR  = 5'b01000;
  localparam logic [4:0] ALU_ROL  = 5'b01001;
  localparam logic [4:0] ALU_MUL  = 5'b01010;
  localparam logic [4:0] ALU_DIV  = 5'b01011;
  localparam logic [4:0] ALU_NEG  = 5'b01100;
  localparam logic [4:0] ALU_NOT  = 5'b01101;

  // Sequencer states (plain constants so legacy code can compare against them)
  typedef logic [3:0] state_t;
  localparam state_t S_RST  = 4'd0;
  localparam state_t S_T0   = 4'd1;
  localparam state_t S_T1   = 4'd2;
  localparam state_t S_T2   = 4'd3;
  localparam state_t S_T3   = 4'd4;
  localparam state_t S_T4   = 4'd5;
  localparam state_t S_T5   = 4'd6;
  localparam state_t S_T6   = 4'd7;
  localparam state_t S_T7   = 4'd8;
  localparam state_t S_HALT = 4'd9;

  // ALU function selected by an arithmetic/logic opcode; immediates share the
  // function of their register-register counterpart.
  function automatic logic [4:0] alu(input logic [4:0] opcode);
    case (opcode)
      OP_ADD, OP_ADDI: alu = ALU_ADD;
      OP_SUB:          alu = ALU_SUB;
      OP_AND, OP_ANDI: alu = ALU_AND;
      OP_OR,  OP_ORI:  alu = ALU_OR;
      OP_ROR:          alu = ALU_ROR;
      OP_ROL:          alu = ALU_ROL;
      OP_SHR:          alu = ALU_SHR;
      OP_SHRA:         alu = ALU_SHRA;
      OP_SHL:          alu = ALU_SHL;
      OP_MUL:          alu = ALU_MUL;
      OP_DIV:          alu = ALU_DIV;
      OP_NEG:          alu = ALU_NEG;
      OP_NOT:          alu = ALU_NOT;
      default:         alu = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Mini-SRC control sequencer (Moore). Fetches an instruction in T0-T2, decodes IR[31:27]
// at the end of T2 and walks the execute micro-steps T3-T7, one step per Clock.
// Ports:
//   Clock, Clear (async active-low), IR (instruction register), CON_Out (branch condition)
//   register loads : PCin IRin HIin LOin ZHighin ZLowin MARin MDRin OutPort Yin
//   bus drives     : PCout HIout LOout ZHighout ZLowout InPort MDRout Cout
//   reg file       : Gra Grb Grc Rin Rout BAout
//   memory / misc  : Read Write IncPC CON_In, OP (ALU function), Run (executing)
module control_unit #(
  parameter logic [4:0] ALU_ADD = mini_src_pkg::ALU_ADD
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_Out,
  output logic        PCin,
  output logic        IRin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighin,
  output logic        ZLowin,
  output logic        MARin,
  output logic        MDRin,
  output logic        OutPort,
  output logic        Yin,
  output logic        PCout,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        InPort,
  output logic        MDRout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        CON_In,
  output logic [4:0]  OP,
  output logic        Run
);
  import mini_src_pkg::*;

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Final execute step of each instruction; nop, halt and unlisted opcodes end at T2.
  function automatic state_t last_step(input logic [4:0] opc);
    case (opc)
      OP_LD, OP_ST:                                        last_step = S_T7;
      OP_MUL, OP_DIV, OP_BR:                               last_step = S_T6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:   last_step = S_T5;
      OP_NEG, OP_NOT:                                      last_step = S_T4;
      OP_JR, OP_MFHI, OP_MFLO, OP_IN, OP_OUT:              last_step = S_T3;
      default:                                             last_step = S_T2;
    endcase
  endfunction

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_RST) begin
      state_d = S_T0;
    end else if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (state_q >= S_T0 && state_q <= S_T7) begin
      if (state_q == S_T2 && opcode == OP_HALT) begin
        state_d = S_HALT;
      end else if (state_q == last_step(opcode)) begin
        state_d = S_T0;
      end else begin
        state_d = state_q + 4'd1;
      end
    end else begin
      state_d = S_RST;
    end
  end

  always_comb begin
    PCin = 1'b0;  IRin = 1'b0;  HIin = 1'b0;   LOin = 1'b0;    ZHighin = 1'b0;
    ZLowin = 1'b0; MARin = 1'b0; MDRin = 1'b0; OutPort = 1'b0; Yin = 1'b0;
    PCout = 1'b0; HIout = 1'b0; LOout = 1'b0;  ZHighout = 1'b0; ZLowout = 1'b0;
    InPort = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    Gra = 1'b0;   Grb = 1'b0;   Grc = 1'b0;    Rin = 1'b0;     Rout = 1'b0;   BAout = 1'b0;
    Read = 1'b0;  Write = 1'b0; IncPC = 1'b0;  CON_In = 1'b0;
    OP = 5'b00000;
    Run = (state_q >= S_T0) && (state_q <= S_T7);

    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_NEG, OP_NOT: begin
            Grb = 1'b1; Rout = 1'b1; OP = alu(opcode); ZHighin = 1'b1; ZLowin = 1'b1;
          end
          OP_MUL, OP_DIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CON_In = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_IN:   begin InPort = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin
            Cout = 1'b1; OP = ALU_ADD; ZHighin = 1'b1; ZLowin = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
            Grc = 1'b1; Rout = 1'b1; OP = alu(opcode); ZHighin = 1'b1; ZLowin = 1'b1;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            Cout = 1'b1; OP = alu(opcode); ZHighin = 1'b1; ZLowin = 1'b1;
          end
          OP_NEG, OP_NOT: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MUL, OP_DIV: begin
            Grb = 1'b1; Rout = 1'b1; OP = alu(opcode); ZHighin = 1'b1; ZLowin = 1'b1;
          end
          OP_BR: begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LD, OP_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MUL, OP_DIV: begin ZLowout = 1'b1; LOin = 1'b1; end
          OP_BR: begin Cout = 1'b1; OP = ALU_ADD; ZHighin = 1'b1; ZLowin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_LD:          begin Read = 1'b1; MDRin = 1'b1; end
          OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          OP_MUL, OP_DIV: begin ZHighout = 1'b1; HIin = 1'b1; end
          // Step is spent even when not taken so branch timing is fixed.
          OP_BR:          begin ZLowout = CON_Out; PCin = CON_Out; end
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: each instruction is expanded into its micro-program (a list of
// expected strobe sets per cycle) and compared cycle by cycle against the DUT.
module tb_control_unit;

  // Opcodes and the address-add function code, taken from the instruction set definition.
  localparam logic [4:0] C_LD = 5'b00000, C_LDI = 5'b00001, C_ST = 5'b00010, C_ADD = 5'b00011;
  localparam logic [4:0] C_SUB = 5'b00100, C_AND = 5'b00101, C_OR = 5'b00110, C_ROR = 5'b00111;
  localparam logic [4:0] C_ROL = 5'b01000, C_SHR = 5'b01001, C_SHRA = 5'b01010;
  localparam logic [4:0] C_SHL = 5'b01011, C_ADDI = 5'b01100, C_ANDI = 5'b01101;
  localparam logic [4:0] C_ORI = 5'b01110, C_DIV = 5'b01111, C_MUL = 5'b10000;
  localparam logic [4:0] C_NEG = 5'b10001, C_NOT = 5'b10010, C_BR = 5'b10011, C_JR = 5'b10100;
  localparam logic [4:0] C_IN = 5'b10110, C_OUT = 5'b10111, C_MFHI = 5'b11000;
  localparam logic [4:0] C_MFLO = 5'b11001, C_NOP = 5'b11010, C_HALT = 5'b11011;
  localparam logic [4:0] F_ADD = 5'b00100;

  localparam logic [27:0] M_PCIN = 28'd1 << 0,   M_IRIN = 28'd1 << 1,   M_HIIN = 28'd1 << 2;
  localparam logic [27:0] M_LOIN = 28'd1 << 3,   M_ZHIN = 28'd1 << 4,   M_ZLIN = 28'd1 << 5;
  localparam logic [27:0] M_MARIN = 28'd1 << 6,  M_MDRIN = 28'd1 << 7,  M_OUTP = 28'd1 << 8;
  localparam logic [27:0] M_YIN = 28'd1 << 9,    M_PCOUT = 28'd1 << 10, M_HIOUT = 28'd1 << 11;
  localparam logic [27:0] M_LOOUT = 28'd1 << 12, M_ZHOUT = 28'd1 << 13, M_ZLOUT = 28'd1 << 14;
  localparam logic [27:0] M_INP = 28'd1 << 15,   M_MDROUT = 28'd1 << 16, M_COUT = 28'd1 << 17;
  localparam logic [27:0] M_GRA = 28'd1 << 18,   M_GRB = 28'd1 << 19,   M_GRC = 28'd1 << 20;
  localparam logic [27:0] M_RIN = 28'd1 << 21,   M_ROUT = 28'd1 << 22,  M_BAOUT = 28'd1 << 23;
  localparam logic [27:0] M_READ = 28'd1 << 24,  M_WRITE = 28'd1 << 25, M_INCPC = 28'd1 << 26;
  localparam logic [27:0] M_CONIN = 28'd1 << 27;
  localparam logic [27:0] M_ZIN = M_ZHIN | M_ZLIN;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        CON_Out = 1'b0;
  logic PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
  logic PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, Run;
  logic [4:0] OP;
  logic [27:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [27:0] s;
    logic [4:0]  op;
  } step_t;
  step_t exp_q[$];

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_Out(CON_Out),
    .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .ZLowin(ZLowin),
    .MARin(MARin), .MDRin(MDRin), .OutPort(OutPort), .Yin(Yin),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .InPort(InPort), .MDRout(MDRout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .Write(Write), .IncPC(IncPC), .CON_In(CON_In), .OP(OP), .Run(Run)
  );

  assign obs = {CON_In, IncPC, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra, Cout, MDRout,
                InPort, ZLowout, ZHighout, LOout, HIout, PCout, Yin, OutPort, MDRin, MARin,
                ZLowin, ZHighin, LOin, HIin, IRin, PCin};

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [4:0] ref_alu(input logic [4:0] opc);
    case (opc)
      C_ADD, C_ADDI: return F_ADD;
      C_SUB:         return mini_src_pkg::ALU_SUB;
      C_AND, C_ANDI: return mini_src_pkg::ALU_AND;
      C_OR, C_ORI:   return mini_src_pkg::ALU_OR;
      C_ROR:         return mini_src_pkg::ALU_ROR;
      C_ROL:         return mini_src_pkg::ALU_ROL;
      C_SHR:         return mini_src_pkg::ALU_SHR;
      C_SHRA:        return mini_src_pkg::ALU_SHRA;
      C_SHL:         return mini_src_pkg::ALU_SHL;
      C_MUL:         return mini_src_pkg::ALU_MUL;
      C_DIV:         return mini_src_pkg::ALU_DIV;
      C_NEG:         return mini_src_pkg::ALU_NEG;
      C_NOT:         return mini_src_pkg::ALU_NOT;
      default:       return 5'b00000;
    endcase
  endfunction

  function automatic void push(input logic [27:0] s, input logic [4:0] op);
    step_t t;
    t.s  = s;
    t.op = op;
    exp_q.push_back(t);
  endfunction

  // Micro-program of one instruction from T0 through its last step.
  function automatic void build(input logic [4:0] opc, input logic con);
    logic [4:0] f;
    f = ref_alu(opc);
    exp_q.delete();
    push(M_PCOUT | M_MARIN | M_INCPC, 5'd0);
    push(M_READ | M_MDRIN, 5'd0);
    push(M_MDROUT | M_IRIN, 5'd0);
    case (opc)
      C_LD, C_ST, C_LDI: begin
        push(M_GRB | M_BAOUT | M_YIN, 5'd0);
        push(M_COUT | M_ZIN, F_ADD);
        if (opc == C_LDI) push(M_ZLOUT | M_GRA | M_RIN, 5'd0);
        else push(M_ZLOUT | M_MARIN, 5'd0);
        if (opc == C_LD) begin
          push(M_READ | M_MDRIN, 5'd0);
          push(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else if (opc == C_ST) begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
          push(M_WRITE, 5'd0);
        end
      end
      C_ADD, C_SUB, C_AND, C_OR, C_SHR, C_SHRA, C_SHL, C_ROR, C_ROL: begin
        push(M_GRB | M_ROUT | M_YIN, 5'd0);
        push(M_GRC | M_ROUT | M_ZIN, f);
        push(M_ZLOUT | M_GRA | M_RIN, 5'd0);
      end
      C_ADDI, C_ANDI, C_ORI: begin
        push(M_GRB | M_ROUT | M_YIN, 5'd0);
        push(M_COUT | M_ZIN, f);
        push(M_ZLOUT | M_GRA | M_RIN, 5'd0);
      end
      C_NEG, C_NOT: begin
        push(M_GRB | M_ROUT | M_ZIN, f);
        push(M_ZLOUT | M_GRA | M_RIN, 5'd0);
      end
      C_MUL, C_DIV: begin
        push(M_GRA | M_ROUT | M_YIN, 5'd0);
        push(M_GRB | M_ROUT | M_ZIN, f);
        push(M_ZLOUT | M_LOIN, 5'd0);
        push(M_ZHOUT | M_HIIN, 5'd0);
      end
      C_BR: begin
        push(M_GRA | M_ROUT | M_CONIN, 5'd0);
        push(M_PCOUT | M_YIN, 5'd0);
        push(M_COUT | M_ZIN, F_ADD);
        push(con ? (M_ZLOUT | M_PCIN) : 28'd0, 5'd0);
      end
      C_JR:   push(M_GRA | M_ROUT | M_PCIN, 5'd0);
      C_MFHI: push(M_HIOUT | M_GRA | M_RIN, 5'd0);
      C_MFLO: push(M_LOOUT | M_GRA | M_RIN, 5'd0);
      C_IN:   push(M_INP | M_GRA | M_RIN, 5'd0);
      C_OUT:  push(M_GRA | M_ROUT | M_OUTP, 5'd0);
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    IR = 32'hDEAD_BEEF;
    CON_Out = 1'b1;
    Clear = 1'b0;
    #2;
    n_checks++;
    if (obs !== 28'd0 || OP !== 5'd0 || Run !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got strobes=%h OP=%b Run=%b, want all 0", obs, OP, Run);
    end
    repeat (3) begin
      @(posedge Clock); #1;
      n_checks++;
      if (obs !== 28'd0 || OP !== 5'd0 || Run !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got strobes=%h OP=%b Run=%b, want all 0", obs, OP, Run);
      end
    end
    @(negedge Clock);
    Clear = 1'b1;
    #1;
    n_checks++;
    if (obs !== 28'd0 || OP !== 5'd0 || Run !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_no_edge: got strobes=%h OP=%b Run=%b, want all 0",
               obs, OP, Run);
    end
  endtask

  task automatic test_directed();
    logic [31:0] d_ir  [5] = '{32'h0880_0075, 32'h1080_0010, 32'h9880_0004, 32'h9880_0004,
                               32'h8118_0000};
    logic        d_con [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    string       d_nm  [5] = '{"ldi", "st", "br_taken", "br_not_taken", "mul"};
    for (int i = 0; i < 5; i++) begin
      int n_write;
      int n_rin;
      n_write = 0;
      n_rin   = 0;
      build(d_ir[i][31:27], d_con[i]);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(posedge Clock); #1;
        if (k == 0) begin
          IR = d_ir[i];
          CON_Out = d_con[i];
        end
        n_write += int'(Write);
        n_rin   += int'(Rin);
        n_checks++;
        if (obs !== exp_q[k].s || OP !== exp_q[k].op || Run !== 1'b1) begin
          n_fail++;
          $display("FAIL %s T%0d: got strobes=%h OP=%b Run=%b, want strobes=%h OP=%b Run=1",
                   d_nm[i], k, obs, OP, Run, exp_q[k].s, exp_q[k].op);
        end
      end
      if (d_nm[i] == "st") begin
        n_checks++;
        if (n_write != 1) begin
          n_fail++;
          $display("FAIL st_write_count: got %0d Write cycles, want 1", n_write);
        end
      end
      if (d_nm[i] == "mul") begin
        n_checks++;
        if (n_rin != 0) begin
          n_fail++;
          $display("FAIL mul_no_rin: got %0d Rin cycles, want 0", n_rin);
        end
      end
    end
  endtask

  // Back-to-back random instructions, including unlisted opcodes (treated as nop).
  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ir;
      logic        con;
      ir  = $urandom();
      con = 1'($urandom_range(0, 1));
      if (ir[31:27] == C_HALT) ir[31:27] = C_NOP;
      build(ir[31:27], con);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(posedge Clock); #1;
        if (k == 0) begin
          IR = ir;
          CON_Out = con;
        end
        n_checks++;
        if (obs !== exp_q[k].s || OP !== exp_q[k].op || Run !== 1'b1) begin
          n_fail++;
          $display("FAIL random opc=%b con=%b T%0d: got strobes=%h OP=%b Run=%b, want %h %b 1",
                   ir[31:27], con, k, obs, OP, Run, exp_q[k].s, exp_q[k].op);
        end
      end
    end
  endtask

  task automatic test_halt();
    build(C_HALT, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge Clock); #1;
      if (k == 0) IR = 32'hD800_1234;
      n_checks++;
      if (obs !== exp_q[k].s || OP !== exp_q[k].op || Run !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_fetch T%0d: got strobes=%h OP=%b Run=%b, want %h %b 1",
                 k, obs, OP, Run, exp_q[k].s, exp_q[k].op);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge Clock); #1;
      n_checks++;
      if (obs !== 28'd0 || OP !== 5'd0 || Run !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_hold cycle %0d: got strobes=%h OP=%b Run=%b, want all 0",
                 c, obs, OP, Run);
      end
    end
    #2;
    Clear = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    build(C_NOP, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge Clock); #1;
      if (k == 0) IR = 32'hD000_0000;
      n_checks++;
      if (obs !== exp_q[k].s || OP !== exp_q[k].op || Run !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_restart T%0d: got strobes=%h OP=%b Run=%b, want %h %b 1",
                 k, obs, OP, Run, exp_q[k].s, exp_q[k].op);
      end
    end
  endtask

  task automatic test_clear_abort();
    build(C_LD, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge Clock); #1;
      if (k == 0) IR = 32'h0088_0020;
      n_checks++;
      if (obs !== exp_q[k].s || OP !== exp_q[k].op || Run !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_ld T%0d: got strobes=%h OP=%b Run=%b, want %h %b 1",
                 k, obs, OP, Run, exp_q[k].s, exp_q[k].op);
      end
    end
    #2;
    Clear = 1'b0;
    #1;
    n_checks++;
    if (obs !== 28'd0 || OP !== 5'd0 || Run !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: got strobes=%h OP=%b Run=%b, want all 0", obs, OP, Run);
    end
    repeat (2) begin
      @(posedge Clock); #1;
      n_checks++;
      if (obs !== 28'd0 || Read !== 1'b0 || MDRin !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_hold: got strobes=%h Read=%b MDRin=%b, want all 0",
                 obs, Read, MDRin);
      end
    end
    @(negedge Clock);
    Clear = 1'b1;
    build(C_ADD, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge Clock); #1;
      if (k == 0) IR = 32'h1912_0000;
      n_checks++;
      if (obs !== exp_q[k].s || OP !== exp_q[k].op || Run !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_restart T%0d: got strobes=%h OP=%b Run=%b, want %h %b 1",
                 k, obs, OP, Run, exp_q[k].s, exp_q[k].op);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_halt();
    test_clear_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
